adc_scan_seq: RTL and testbench

- Avalon-ST initiator for the on-chip modular ADC core: drives its command sink and consumes its response source.
- Walks a programmable list of up to 8 channel slots and issues one conversion command per slot.
- Checks each response against the expected channel and latches 12-bit results per slot for the MCU register file.
- Supports single-shot and continuous scanning, with a response timeout.

---
 rtl/adc_scan_seq_if.sv | 41 ++++
 rtl/adc_scan_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_adc_scan_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_seq_if.sv
// Avalon-ST command/response link between the scan sequencer and the modular ADC core.
// master = sequencer side, slave = ADC core side.
interface adc_scan_seq_if;
  logic        command_valid;
  logic [4:0]  command_channel;
  logic        command_startofpacket;
  logic        command_endofpacket;
  logic        command_ready;

  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        response_startofpacket;
  logic        response_endofpacket;

  modport master (
    output command_valid,
    output command_channel,
    output command_startofpacket,
    output command_endofpacket,
    input  command_ready,
    input  response_valid,
    input  response_channel,
    input  response_data,
    input  response_startofpacket,
    input  response_endofpacket
  );

  modport slave (
    input  command_valid,
    input  command_channel,
    input  command_startofpacket,
    input  command_endofpacket,
    output command_ready,
    output response_valid,
    output response_channel,
    output response_data,
    output response_startofpacket,
    output response_endofpacket
  );
endinterface

// File: rtl/adc_scan_seq.sv
// Scan sequencer for the modular ADC core: walks a channel slot table, issues one command per
// slot, checks each response channel and latches 12-bit results per slot.
module adc_scan_seq #(
  parameter int unsigned MAX_SLOTS      = 8,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 clock_clk,
  input  logic                 reset_sink_reset_n,

  input  logic                 cfg_we,
  input  logic [2:0]           cfg_slot,
  input  logic [4:0]           cfg_channel,
  input  logic [2:0]           scan_len,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 stop,

  adc_scan_seq_if.master       adc,

  input  logic [2:0]           result_sel,
  output logic [11:0]          result_data,
  output logic [MAX_SLOTS-1:0] result_mask,
  output logic                 busy,
  output logic                 scan_done,
  output logic                 err_mismatch,
  output logic                 err_timeout,
  input  logic                 err_clear
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StResp,
    StGap
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           slot_q, slot_d;
  logic [4:0]           cmd_chan_q, cmd_chan_d;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
  logic                 cont_q, cont_d;
  logic                 stop_req_q, stop_req_d;
  logic                 scan_done_q, scan_done_d;
  logic                 err_mismatch_q, err_mismatch_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [MAX_SLOTS-1:0] mask_q, mask_d;
  logic [4:0]           table_q [MAX_SLOTS];
  logic [4:0]           table_d [MAX_SLOTS];
  logic [11:0]          result_q [MAX_SLOTS];
  logic [11:0]          result_d [MAX_SLOTS];

  logic       set_mismatch;
  logic       set_timeout;
  logic       resolved;
  logic       last_slot;
  logic [2:0] slot_inc;

  // The ADC's packet markers on the response side carry no information we need.
  logic unused_resp_marks;
  assign unused_resp_marks = adc.response_startofpacket ^ adc.response_endofpacket;

  assign last_slot = (slot_q == scan_len);
  assign slot_inc  = slot_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cmd_chan_d   = cmd_chan_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cont_d       = cont_q;
    stop_req_d   = stop_req_q;
    mask_d       = mask_q;
    table_d      = table_q;
    result_d     = result_q;
    scan_done_d  = 1'b0;
    set_mismatch = 1'b0;
    set_timeout  = 1'b0;
    resolved     = 1'b0;

    // Table reads below use table_q, so a write landing on the same edge as a CMD entry
    // for that slot leaves the outgoing command on the old channel.
    if (cfg_we) begin
      table_d[cfg_slot] = cfg_channel;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCmd;
          slot_d     = 3'd0;
          cmd_chan_d = table_q[0];
          mask_d     = '0;
          cont_d     = continuous;
          stop_req_d = 1'b0;
        end
      end

      StCmd: begin
        if (stop) begin
          stop_req_d = 1'b1;
          cont_d     = 1'b0;
        end
        if (adc.command_ready) begin
          state_d   = StResp;
          tmo_cnt_d = '0;
        end
      end

      StResp: begin
        if (stop) begin
          stop_req_d = 1'b1;
          cont_d     = 1'b0;
        end

        if (adc.response_valid) begin
          resolved = 1'b1;
          if (adc.response_channel == cmd_chan_q) begin
            result_d[slot_q] = adc.response_data;
            mask_d[slot_q]   = 1'b1;
          end else begin
            set_mismatch = 1'b1;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          resolved    = 1'b1;
          set_timeout = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        if (resolved) begin
          if (!last_slot) begin
            state_d    = StCmd;
            slot_d     = slot_inc;
            cmd_chan_d = table_q[slot_inc];
          end else begin
            scan_done_d = 1'b1;
            if (cont_d && !stop_req_d) begin
              state_d   = StGap;
              gap_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end

      StGap: begin
        if (stop || stop_req_q) begin
          state_d = StIdle;
        end else if (gap_cnt_q == GapLast) begin
          state_d    = StCmd;
          slot_d     = 3'd0;
          cmd_chan_d = table_q[0];
          mask_d     = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    // The core has no backpressure, so a stray response can only be dropped and flagged.
    if ((state_q != StResp) && adc.response_valid) begin
      set_mismatch = 1'b1;
    end

    // Set beats clear when both happen in the same cycle.
    err_mismatch_d = set_mismatch ? 1'b1 : (err_clear ? 1'b0 : err_mismatch_q);
    err_timeout_d  = set_timeout  ? 1'b1 : (err_clear ? 1'b0 : err_timeout_q);
  end

  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q        <= StIdle;
      slot_q         <= '0;
      cmd_chan_q     <= '0;
      tmo_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      cont_q         <= 1'b0;
      stop_req_q     <= 1'b0;
      scan_done_q    <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      mask_q         <= '0;
      table_q        <= '{default: '0};
      result_q       <= '{default: '0};
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      cmd_chan_q     <= cmd_chan_d;
      tmo_cnt_q      <= tmo_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      cont_q         <= cont_d;
      stop_req_q     <= stop_req_d;
      scan_done_q    <= scan_done_d;
      err_mismatch_q <= err_mismatch_d;
      err_timeout_q  <= err_timeout_d;
      mask_q         <= mask_d;
      table_q        <= table_d;
      result_q       <= result_d;
    end
  end

  // Packet markers are gated by state so nothing toggles while idle or in reset.
  always_comb begin
    adc.command_valid         = (state_q == StCmd);
    adc.command_channel       = cmd_chan_q;
    adc.command_startofpacket = (state_q == StCmd) && (slot_q == 3'd0);
    adc.command_endofpacket   = (state_q == StCmd) && last_slot;
  end

  assign result_data  = result_q[result_sel];
  assign result_mask  = mask_q;
  assign busy         = (state_q != StIdle);
  assign scan_done    = scan_done_q;
  assign err_mismatch = err_mismatch_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed bench for adc_scan_seq: an ADC responder model plus queues of expected commands
// and expected slot results that are compared as the DUT produces them.
module tb_adc_scan_seq;
  localparam int unsigned Timeout = 1023;
  localparam int unsigned Gap     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_slot;
  logic [4:0]  cfg_channel;
  logic [2:0]  scan_len;
  logic        start, continuous, stop, err_clear;
  logic [2:0]  result_sel;
  logic [11:0] result_data;
  logic [7:0]  result_mask;
  logic        busy, scan_done, err_mismatch, err_timeout;

  adc_scan_seq_if ifc ();

  adc_scan_seq #(
    .MAX_SLOTS      (8),
    .GAP_CYCLES     (Gap),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clock_clk          (clk),
    .reset_sink_reset_n (rst_n),
    .cfg_we             (cfg_we),
    .cfg_slot           (cfg_slot),
    .cfg_channel        (cfg_channel),
    .scan_len           (scan_len),
    .start              (start),
    .continuous         (continuous),
    .stop               (stop),
    .adc                (ifc),
    .result_sel         (result_sel),
    .result_data        (result_data),
    .result_mask        (result_mask),
    .busy               (busy),
    .scan_done          (scan_done),
    .err_mismatch       (err_mismatch),
    .err_timeout        (err_timeout),
    .err_clear          (err_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Scoreboard queues: commands packed {channel, sop, eop}; results packed {slot, data}.
  logic [6:0]  exp_cmd [$];
  logic [6:0]  cmd_log [$];
  logic [14:0] exp_res [$];
  logic [11:0] rsp_data_q [$];

  // Responder controls
  int         rsp_cnt   = 0;
  logic [4:0] pend_chan = '0;
  int         hs_cyc    = 0;
  int         bp_idx    = -1;
  int         bp_left   = 0;
  int         bp_stalls = 0;
  bit         bp_stable = 1'b1;
  logic [4:0] bp_chan   = '0;
  int         mm_idx    = -1;
  int         drop_idx  = -1;
  int         tmo_cyc   = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC core model: answers 4 cycles after each handshake, with optional stall/mismatch/drop.
  initial begin
    ifc.command_ready          = 1'b1;
    ifc.response_valid         = 1'b0;
    ifc.response_channel       = '0;
    ifc.response_data          = '0;
    ifc.response_startofpacket = 1'b0;
    ifc.response_endofpacket   = 1'b0;
    forever begin
      @(negedge clk);
      ifc.response_valid = 1'b0;
      if (!rst_n) begin
        rsp_cnt = 0;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          ifc.response_valid   = 1'b1;
          ifc.response_channel = pend_chan;
          ifc.response_data    = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : 12'h0;
        end
      end
      ifc.command_ready = 1'b1;
      if (ifc.command_valid && cmd_log.size() == bp_idx && bp_left > 0) begin
        if (bp_stalls == 0) bp_chan = ifc.command_channel;
        else if (ifc.command_channel != bp_chan) bp_stable = 1'b0;
        ifc.command_ready = 1'b0;
        bp_left--;
        bp_stalls++;
      end
      if (rst_n && ifc.command_valid && ifc.command_ready) begin
        if (bp_stalls > 0 && cmd_log.size() == bp_idx && ifc.command_channel != bp_chan)
          bp_stable = 1'b0;
        hs_cyc    = cyc;
        pend_chan = (cmd_log.size() == mm_idx) ? 5'd9 : ifc.command_channel;
        rsp_cnt   = (cmd_log.size() == drop_idx) ? 0 : 4;
        cmd_log.push_back({ifc.command_channel, ifc.command_startofpacket,
                           ifc.command_endofpacket});
      end
    end
  end

  task automatic cfg_write(input logic [2:0] s, input logic [4:0] ch);
    @(negedge clk);
    cfg_we = 1'b1; cfg_slot = s; cfg_channel = ch;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_table();
    cfg_write(3'd0, 5'd3);
    cfg_write(3'd1, 5'd5);
    cfg_write(3'd2, 5'd0);
    cfg_write(3'd3, 5'd7);
  endtask

  task automatic push_std_cmds();
    exp_cmd.push_back({5'd3, 1'b1, 1'b0});
    exp_cmd.push_back({5'd5, 1'b0, 1'b0});
    exp_cmd.push_back({5'd0, 1'b0, 1'b0});
    exp_cmd.push_back({5'd7, 1'b0, 1'b1});
  endtask

  task automatic push_rsp(input logic [2:0] s, input logic [11:0] d, input bit expect_store);
    rsp_data_q.push_back(d);
    if (expect_store) exp_res.push_back({s, d});
  endtask

  task automatic check_cmds(input string tag);
    chk({tag, "_cmd_count"}, 32'(cmd_log.size()), 32'(exp_cmd.size()));
    while (exp_cmd.size() > 0) begin
      logic [6:0] e;
      e = exp_cmd.pop_front();
      if (cmd_log.size() > 0) chk({tag, "_cmd"}, 32'(cmd_log.pop_front()), 32'(e));
    end
    cmd_log.delete();
  endtask

  task automatic check_results(input string tag);
    while (exp_res.size() > 0) begin
      logic [14:0] e;
      e = exp_res.pop_front();
      result_sel = e[14:12];
      #1;
      chk({tag, "_result"}, 32'(result_data), 32'(e[11:0]));
    end
  endtask

  task automatic run_scan(input int budget, output int dn);
    tmo_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("valid_after_start", 32'(ifc.command_valid), 32'd1);
    dn = 0;
    for (int i = 0; i < budget; i++) begin
      if (scan_done) dn++;
      if (err_timeout && tmo_cyc < 0) tmo_cyc = cyc;
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse_err_clear();
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
  endtask

  initial begin
    int dn, done_cyc, gap, extra;
    bit prev_v, stopped;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_channel = '0; scan_len = '0;
    start = 1'b0; continuous = 1'b0; stop = 1'b0; err_clear = 1'b0; result_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ifc.command_valid), 32'd0);
    chk("rst_channel", 32'(ifc.command_channel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mask", 32'(result_mask), 32'd0);
    chk("rst_data", 32'(result_data), 32'd0);
    chk("rst_errs", 32'({err_mismatch, err_timeout, scan_done}), 32'd0);
    rst_n = 1'b1;

    // Single scan over four slots
    load_table();
    scan_len = 3'd3;
    push_std_cmds();
    push_rsp(3'd0, 12'h123, 1'b1);
    push_rsp(3'd1, 12'h456, 1'b1);
    push_rsp(3'd2, 12'h789, 1'b1);
    push_rsp(3'd3, 12'hABC, 1'b1);
    run_scan(200, dn);
    chk("single_done_pulses", 32'(dn), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_mask", 32'(result_mask), 32'h0F);
    check_cmds("single");
    check_results("single");

    // Backpressure on slot 1
    bp_idx = 1; bp_left = 5; bp_stalls = 0; bp_stable = 1'b1;
    push_std_cmds();
    push_rsp(3'd0, 12'h0A1, 1'b1);
    push_rsp(3'd1, 12'h0B2, 1'b1);
    push_rsp(3'd2, 12'h0C3, 1'b1);
    push_rsp(3'd3, 12'h0D4, 1'b1);
    run_scan(200, dn);
    bp_idx = -1;
    chk("bp_stalls", 32'(bp_stalls), 32'd5);
    chk("bp_stable", 32'(bp_stable), 32'd1);
    chk("bp_done_pulses", 32'(dn), 32'd1);
    check_cmds("bp");
    check_results("bp");

    // Channel mismatch on slot 2: old result must survive
    mm_idx = 2;
    push_std_cmds();
    push_rsp(3'd0, 12'h311, 1'b1);
    push_rsp(3'd1, 12'h322, 1'b1);
    push_rsp(3'd2, 12'h333, 1'b0);
    push_rsp(3'd3, 12'h344, 1'b1);
    exp_res.push_back({3'd2, 12'h0C3});
    run_scan(200, dn);
    mm_idx = -1;
    chk("mm_err", 32'(err_mismatch), 32'd1);
    chk("mm_mask", 32'(result_mask), 32'h0B);
    chk("mm_done_pulses", 32'(dn), 32'd1);
    check_cmds("mm");
    check_results("mm");
    pulse_err_clear();
    chk("mm_err_cleared", 32'(err_mismatch), 32'd0);

    // Timeout on a one-slot scan
    scan_len = 3'd0; drop_idx = 0;
    exp_cmd.push_back({5'd3, 1'b1, 1'b1});
    run_scan(Timeout + 100, dn);
    drop_idx = -1;
    chk("tmo_err", 32'(err_timeout), 32'd1);
    chk("tmo_latency", 32'(tmo_cyc - (hs_cyc + 1)), 32'(Timeout));
    chk("tmo_done_pulses", 32'(dn), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_mask", 32'(result_mask), 32'd0);
    check_cmds("tmo");
    pulse_err_clear();
    chk("tmo_err_cleared", 32'(err_timeout), 32'd0);

    // Continuous mode, stopped during slot 1 of the second scan
    scan_len = 3'd1; continuous = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_cmd.push_back({5'd3, 1'b1, 1'b0});
      exp_cmd.push_back({5'd5, 1'b0, 1'b1});
    end
    push_rsp(3'd0, 12'h111, 1'b0);
    push_rsp(3'd1, 12'h222, 1'b0);
    push_rsp(3'd0, 12'h333, 1'b1);
    push_rsp(3'd1, 12'h444, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    continuous = 1'b0;
    prev_v = ifc.command_valid;
    dn = 0; done_cyc = 0; gap = -1; stopped = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stop = 1'b0;
      if (scan_done) begin dn++; done_cyc = cyc; end
      if (ifc.command_valid && !prev_v && ifc.command_startofpacket && dn == 1 && gap < 0)
        gap = cyc - done_cyc;
      if (dn == 1 && ifc.command_valid && ifc.command_endofpacket && !stopped) begin
        stop = 1'b1; stopped = 1'b1;
      end
      prev_v = ifc.command_valid;
      if (!busy) break;
    end
    stop = 1'b0;
    chk("cont_gap", 32'(gap), 32'(Gap + 1));
    chk("cont_done_pulses", 32'(dn), 32'd2);
    chk("cont_busy", 32'(busy), 32'd0);
    chk("cont_mask", 32'(result_mask), 32'h03);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.command_valid) extra++;
    end
    chk("cont_no_more_cmds", 32'(extra), 32'd0);
    check_cmds("cont");
    check_results("cont");

    // Reset asserted while waiting for a response
    scan_len = 3'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("rstr_in_resp", 32'({busy, ifc.command_valid}), 32'b10);
    result_sel = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstr_busy", 32'(busy), 32'd0);
    chk("rstr_valid", 32'(ifc.command_valid), 32'd0);
    chk("rstr_mask", 32'(result_mask), 32'd0);
    chk("rstr_data", 32'(result_data), 32'd0);
    chk("rstr_marks", 32'({ifc.command_startofpacket, ifc.command_endofpacket}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd_log.delete();
    load_table();
    push_std_cmds();
    push_rsp(3'd0, 12'hF01, 1'b1);
    push_rsp(3'd1, 12'hF02, 1'b1);
    push_rsp(3'd2, 12'hF03, 1'b1);
    push_rsp(3'd3, 12'hF04, 1'b1);
    run_scan(200, dn);
    chk("post_rst_done", 32'(dn), 32'd1);
    chk("post_rst_mask", 32'(result_mask), 32'h0F);
    chk("post_rst_errs", 32'({err_mismatch, err_timeout}), 32'd0);
    check_cmds("post_rst");
    check_results("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
